// File: rtl/mbox_pf_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mbox_pf_seq                                                  |
// | Description : MBOX cycle sequencer that arbitrates normal completion,      |
// |               hardware-error / page-fail holds and bounded EBOX retries.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mbox_pf_seq (
  input  logic         clk,
  input  logic         CROBAR,
  input  logic         ebxReq,
  input  logic         mboxDone,
  input  logic [27:35] vma,
  input  logic         CSH_ADR_PAR_ERR,
  input  logic         MB_PAR_ERR,
  input  logic         ADR_PAR_ERR,
  input  logic         NXM_ERR,
  input  logic         SBUS_ERR,
  input  logic         PF_EBOX_HANDLE,
  input  logic         PT_PUBLIC,
  input  logic         ebxPfAck,
  input  logic         errClr,
  output logic [0:10]  pfDisp,
  output logic         PAGE_FAIL_HOLD,
  output logic         EBOX_RETRY_REQ,
  output logic         MBOX_RESP_IN,
  output logic [27:35] MBOX_GATE_VMA,
  output logic [0:4]   errSticky,
  output logic         busy
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CYCLE  = 3'd1;
  localparam logic [2:0] c_RESP   = 3'd2;
  localparam logic [2:0] c_PFHOLD = 3'd3;
  localparam logic [2:0] c_RETRY  = 3'd4;

  localparam logic [4:0] c_CODE_ADR_PAR = 5'h13;
  localparam logic [4:0] c_CODE_CSH_PAR = 5'h11;
  localparam logic [4:0] c_CODE_MB_PAR  = 5'h12;
  localparam logic [4:0] c_CODE_NXM     = 5'h14;
  localparam logic [4:0] c_CODE_SBUS    = 5'h15;
  localparam logic [4:0] c_CODE_PF_PUB  = 5'h02;
  localparam logic [4:0] c_CODE_PF_PRIV = 5'h01;
  localparam logic [4:0] c_CODE_EXHAUST = 5'h1F;

  localparam logic [1:0] c_RETRY_MAX = 2'd3;

  logic [2:0]   r_state;
  logic [2:0]   w_next_state;
  logic [1:0]   r_retry_cnt;
  logic         r_hard_err;
  logic         r_exhausted;
  logic [0:10]  r_pf_disp;
  logic [27:35] r_gate_vma;
  logic [0:4]   r_sticky;

  logic [0:4]   w_err_vec;
  logic         w_hard;
  logic         w_fault;
  logic         w_in_cycle;
  logic         w_retry_full;
  logic [4:0]   w_code;

  // Error vector ordering matches errSticky: ADR, CSH, MB, NXM, SBUS
  assign w_err_vec    = {ADR_PAR_ERR, CSH_ADR_PAR_ERR, MB_PAR_ERR, NXM_ERR, SBUS_ERR};
  assign w_hard       = |w_err_vec;
  assign w_fault      = w_hard | PF_EBOX_HANDLE;
  assign w_in_cycle   = (r_state == c_CYCLE);
  assign w_retry_full = (r_retry_cnt == c_RETRY_MAX);

  always_comb begin
    w_code = c_CODE_PF_PRIV;
    if (ADR_PAR_ERR)           w_code = c_CODE_ADR_PAR;
    else if (CSH_ADR_PAR_ERR)  w_code = c_CODE_CSH_PAR;
    else if (MB_PAR_ERR)       w_code = c_CODE_MB_PAR;
    else if (NXM_ERR)          w_code = c_CODE_NXM;
    else if (SBUS_ERR)         w_code = c_CODE_SBUS;
    else if (w_retry_full)     w_code = c_CODE_EXHAUST;
    else if (PT_PUBLIC)        w_code = c_CODE_PF_PUB;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (ebxReq) w_next_state = c_CYCLE;
      end
      c_CYCLE: begin
        // A fault outranks a completion seen on the same clock
        if (w_fault)       w_next_state = c_PFHOLD;
        else if (mboxDone) w_next_state = c_RESP;
      end
      c_RESP: begin
        w_next_state = c_IDLE;
      end
      c_PFHOLD: begin
        if (ebxPfAck) begin
          if (r_hard_err || r_exhausted) w_next_state = c_IDLE;
          else                           w_next_state = c_RETRY;
        end
      end
      c_RETRY: begin
        w_next_state = c_CYCLE;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // VMA is sampled only on a fresh start, so retries reuse the original address
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_gate_vma <= '0;
    end else if (r_state == c_IDLE && ebxReq) begin
      r_gate_vma <= vma;
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_pf_disp   <= '0;
      r_hard_err  <= 1'b0;
      r_exhausted <= 1'b0;
    end else if (w_in_cycle && w_fault) begin
      r_pf_disp   <= {w_code, r_gate_vma[30:35]};
      r_hard_err  <= w_hard;
      r_exhausted <= ~w_hard & w_retry_full;
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_retry_cnt <= '0;
    end else begin
      case (r_state)
        c_RESP: begin
          r_retry_cnt <= '0;
        end
        c_RETRY: begin
          if (!w_retry_full) r_retry_cnt <= r_retry_cnt + 2'd1;
        end
        c_PFHOLD: begin
          if (ebxPfAck && r_hard_err) r_retry_cnt <= '0;
        end
        default: begin
          r_retry_cnt <= r_retry_cnt;
        end
      endcase
    end
  end

  // A new error on the clearing clock survives the clear
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~{5{errClr}}) | (w_in_cycle ? w_err_vec : 5'b00000);
    end
  end

  // Status strobes decode straight from state so reset removes them at once
  assign pfDisp         = r_pf_disp;
  assign PAGE_FAIL_HOLD = (r_state == c_PFHOLD);
  assign EBOX_RETRY_REQ = (r_state == c_RETRY);
  assign MBOX_RESP_IN   = (r_state == c_RESP);
  assign MBOX_GATE_VMA  = r_gate_vma;
  assign errSticky      = r_sticky;
  assign busy           = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mbox_pf_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mbox_pf_seq                                               |
// | Description : Table-driven, scoreboarded bench for mbox_pf_seq.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mbox_pf_seq;

  logic         clk = 1'b0;
  logic         CROBAR;
  logic         ebxReq, mboxDone;
  logic [27:35] vma;
  logic         CSH_ADR_PAR_ERR, MB_PAR_ERR, ADR_PAR_ERR, NXM_ERR, SBUS_ERR;
  logic         PF_EBOX_HANDLE, PT_PUBLIC, ebxPfAck, errClr;
  logic [0:10]  pfDisp;
  logic         PAGE_FAIL_HOLD, EBOX_RETRY_REQ, MBOX_RESP_IN;
  logic [27:35] MBOX_GATE_VMA;
  logic [0:4]   errSticky;
  logic         busy;

  mbox_pf_seq dut (
    .clk(clk), .CROBAR(CROBAR), .ebxReq(ebxReq), .mboxDone(mboxDone), .vma(vma),
    .CSH_ADR_PAR_ERR(CSH_ADR_PAR_ERR), .MB_PAR_ERR(MB_PAR_ERR), .ADR_PAR_ERR(ADR_PAR_ERR),
    .NXM_ERR(NXM_ERR), .SBUS_ERR(SBUS_ERR), .PF_EBOX_HANDLE(PF_EBOX_HANDLE),
    .PT_PUBLIC(PT_PUBLIC), .ebxPfAck(ebxPfAck), .errClr(errClr), .pfDisp(pfDisp),
    .PAGE_FAIL_HOLD(PAGE_FAIL_HOLD), .EBOX_RETRY_REQ(EBOX_RETRY_REQ),
    .MBOX_RESP_IN(MBOX_RESP_IN), .MBOX_GATE_VMA(MBOX_GATE_VMA),
    .errSticky(errSticky), .busy(busy)
  );

  always #5 clk = ~clk;

  // err order: ADR, CSH, MB, NXM, SBUS
  typedef struct {
    bit         start;
    logic [8:0] vma;
    logic [0:4] err;
    logic       pf;
    logic       pub;
    logic       done;
    logic       resp;
    logic [4:0] code;
    logic       retry;
  } vec_t;

  typedef struct {
    logic        resp;
    logic [10:0] disp;
    logic [8:0]  gvma;
  } exp_t;

  vec_t       tbl [14];
  exp_t       exp_q [$];
  logic [0:4] model_sticky;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ebxReq = 0; mboxDone = 0; ebxPfAck = 0; errClr = 0;
    CSH_ADR_PAR_ERR = 0; MB_PAR_ERR = 0; ADR_PAR_ERR = 0; NXM_ERR = 0; SBUS_ERR = 0;
    PF_EBOX_HANDLE = 0; PT_PUBLIC = 0;
  endtask

  task automatic start_cyc(input logic [8:0] a);
    ebxReq = 1; vma = a;
    @(negedge clk);
    ebxReq = 0; vma = ~a;
  endtask

  task automatic pulse_ack();
    ebxPfAck = 1;
    @(negedge clk);
    ebxPfAck = 0;
  endtask

  task automatic fault_pf(input logic pub);
    PF_EBOX_HANDLE = 1; PT_PUBLIC = pub;
    @(negedge clk);
    PF_EBOX_HANDLE = 0; PT_PUBLIC = 0;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    exp_t e;
    bit   got;
    if (v.start) begin
      errClr = 1;
      @(negedge clk);
      errClr = 0;
      model_sticky = '0;
      start_cyc(v.vma);
    end else begin
      vma = ~v.vma;
    end
    if (v.err == 5'b00000 && !v.pf) begin
      @(negedge clk);
      check($sformatf("row%0d_wait_resp", idx), {31'd0, MBOX_RESP_IN}, 32'd0);
    end
    {ADR_PAR_ERR, CSH_ADR_PAR_ERR, MB_PAR_ERR, NXM_ERR, SBUS_ERR} = v.err;
    PF_EBOX_HANDLE = v.pf; PT_PUBLIC = v.pub; mboxDone = v.done;
    e.resp = v.resp; e.disp = {v.code, v.vma[5:0]}; e.gvma = v.vma;
    exp_q.push_back(e);
    model_sticky = model_sticky | v.err;
    @(negedge clk);
    clear_inputs();
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (MBOX_RESP_IN || PAGE_FAIL_HOLD) got = 1;
      else @(negedge clk);
    end
    e = exp_q.pop_front();
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL row%0d_timeout: got no response expected resp=%0d", idx, e.resp);
      return;
    end
    check($sformatf("row%0d_gate_vma", idx), {23'd0, MBOX_GATE_VMA}, {23'd0, e.gvma});
    if (e.resp) begin
      check($sformatf("row%0d_resp", idx), {31'd0, MBOX_RESP_IN}, 32'd1);
      @(negedge clk);
      check($sformatf("row%0d_resp_pulse", idx), {30'd0, MBOX_RESP_IN, busy}, 32'd0);
    end else begin
      check($sformatf("row%0d_pfhold", idx), {31'd0, PAGE_FAIL_HOLD}, 32'd1);
      check($sformatf("row%0d_pfdisp", idx), {21'd0, pfDisp}, {21'd0, e.disp});
      @(negedge clk);
      check($sformatf("row%0d_pfdisp_hold", idx), {20'd0, PAGE_FAIL_HOLD, pfDisp}, {20'd0, 1'b1, e.disp});
      pulse_ack();
      if (v.retry) begin
        check($sformatf("row%0d_retry", idx), {31'd0, EBOX_RETRY_REQ}, 32'd1);
        @(negedge clk);
        check($sformatf("row%0d_retry_pulse", idx), {30'd0, EBOX_RETRY_REQ, busy}, 32'd1);
      end else begin
        check($sformatf("row%0d_idle", idx), {30'd0, EBOX_RETRY_REQ, busy}, 32'd0);
      end
    end
    check($sformatf("row%0d_sticky", idx), {27'd0, errSticky}, {27'd0, model_sticky});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          start  vma      err       pf    pub   done  resp  code   retry
    tbl[0]  = '{1'b1, 9'o123, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, 5'h00, 1'b0};
    tbl[1]  = '{1'b1, 9'o077, 5'b00110, 1'b0, 1'b0, 1'b0, 1'b0, 5'h12, 1'b0};
    tbl[2]  = '{1'b1, 9'o055, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 5'h02, 1'b1};
    tbl[3]  = '{1'b0, 9'o055, 5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 5'h13, 1'b0};
    tbl[4]  = '{1'b1, 9'o201, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 5'h11, 1'b0};
    tbl[5]  = '{1'b1, 9'o302, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 5'h01, 1'b1};
    tbl[6]  = '{1'b0, 9'o302, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 5'h01, 1'b1};
    tbl[7]  = '{1'b0, 9'o302, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 5'h01, 1'b1};
    tbl[8]  = '{1'b0, 9'o302, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 5'h1F, 1'b0};
    tbl[9]  = '{1'b1, 9'o111, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, 5'h00, 1'b0};
    tbl[10] = '{1'b1, 9'o333, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 5'h02, 1'b1};
    tbl[11] = '{1'b0, 9'o333, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, 5'h00, 1'b0};
    tbl[12] = '{1'b1, 9'o222, 5'b00001, 1'b0, 1'b0, 1'b1, 1'b0, 5'h15, 1'b0};
    tbl[13] = '{1'b1, 9'o444, 5'b00010, 1'b1, 1'b1, 1'b0, 1'b0, 5'h14, 1'b0};

    clear_inputs();
    vma = 9'o000;
    model_sticky = '0;
    CROBAR = 1;
    #1;
    check("reset_outputs", {8'd0, pfDisp, PAGE_FAIL_HOLD, EBOX_RETRY_REQ, MBOX_RESP_IN, busy, errSticky},
          32'd0);
    check("reset_gate_vma", {23'd0, MBOX_GATE_VMA}, 32'd0);
    repeat (2) @(negedge clk);
    CROBAR = 0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_row(i, tbl[i]);

    // Inputs outside their owning states are ignored
    errClr = 1;
    @(negedge clk);
    errClr = 0;
    check("errclr_clears", {27'd0, errSticky}, 32'd0);
    NXM_ERR = 1; ebxPfAck = 1; mboxDone = 1;
    @(negedge clk);
    clear_inputs();
    check("idle_ignores_err", {26'd0, busy, errSticky}, 32'd0);
    start_cyc(9'o070);
    SBUS_ERR = 1;
    @(negedge clk);
    SBUS_ERR = 0;
    ebxReq = 1; vma = 9'o555;
    @(negedge clk);
    ebxReq = 0;
    check("pfhold_ignores_req", {22'd0, PAGE_FAIL_HOLD, MBOX_GATE_VMA}, {22'd0, 1'b1, 9'o070});
    check("sbus_sticky", {27'd0, errSticky}, 32'd1);
    pulse_ack();

    // Set and clear on the same clock: set wins
    start_cyc(9'o071);
    SBUS_ERR = 1; errClr = 1;
    @(negedge clk);
    clear_inputs();
    check("set_beats_clr", {27'd0, errSticky}, 32'd1);
    check("set_beats_clr_disp", {21'd0, pfDisp}, {21'd0, 5'h15, 6'o71});
    pulse_ack();
    errClr = 1;
    @(negedge clk);
    errClr = 0;
    check("clr_after", {27'd0, errSticky}, 32'd0);

    // Exhaust retries, then reset asynchronously in PFHOLD
    start_cyc(9'o246);
    for (int r = 0; r < 3; r++) begin
      fault_pf(1'b0);
      check($sformatf("exh_code%0d", r), {21'd0, pfDisp}, {21'd0, 5'h01, 6'o46});
      pulse_ack();
      check($sformatf("exh_retry%0d", r), {31'd0, EBOX_RETRY_REQ}, 32'd1);
      @(negedge clk);
    end
    fault_pf(1'b0);
    check("exh_1f", {20'd0, PAGE_FAIL_HOLD, pfDisp}, {20'd0, 1'b1, 5'h1F, 6'o46});
    #2 CROBAR = 1;
    #1;
    check("async_rst_pfhold", {19'd0, PAGE_FAIL_HOLD, busy, pfDisp}, 32'd0);
    #1 CROBAR = 0;
    @(negedge clk);
    start_cyc(9'o013);
    fault_pf(1'b0);
    check("fresh_count", {21'd0, pfDisp}, {21'd0, 5'h01, 6'o13});
    pulse_ack();
    check("retry_before_rst", {31'd0, EBOX_RETRY_REQ}, 32'd1);
    #2 CROBAR = 1;
    #1;
    check("async_rst_retry", {30'd0, EBOX_RETRY_REQ, busy}, 32'd0);
    #1 CROBAR = 0;
    @(negedge clk);
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
